alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: grant, register operands, capture result, hold response.
// Optional feature: define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise req0 has fixed priority.

package alu_arbiter_pkg;
  localparam int unsigned DataW = 32;
  localparam int unsigned OpW   = 3;

  typedef struct packed {
    logic [OpW-1:0]   op;
    logic [DataW-1:0] a;
    logic [DataW-1:0] b;
  } alu_cmd_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DataW-1:0] req0_a,
  input  logic [DataW-1:0] req0_b,
  input  logic [OpW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DataW-1:0] req1_a,
  input  logic [DataW-1:0] req1_b,
  input  logic [OpW-1:0]   req1_op,
  output logic [DataW-1:0] alu_a,
  output logic [DataW-1:0] alu_b,
  output logic [OpW-1:0]   alu_op,
  input  logic [DataW-1:0] alu_z,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DataW-1:0] rsp_z,
  output logic             rsp_zero,
  output logic             rsp_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  alu_cmd_t         cmd_q, cmd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DataW-1:0] rsp_z_q, rsp_z_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_id_q, rsp_id_d;
  logic             any_valid;
  logic             pick1;

  assign any_valid = req0_valid || req1_valid;

`ifdef ALU_ARB_RR_EN
  // last_q holds the index of the most recently accepted requester; the other one wins a tie.
  logic last_q, last_d;
  assign pick1 = req1_valid && (!req0_valid || !last_q);
`else
  assign pick1 = req1_valid && !req0_valid;
`endif

  // Next-state, datapath load and combinational ready generation.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_z_d     = rsp_z_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_id_d    = rsp_id_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
`ifdef ALU_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req0_ready = !pick1;
          req1_ready = pick1;
          if (pick1) begin
            cmd_d.op = req1_op;
            cmd_d.a  = req1_a;
            cmd_d.b  = req1_b;
          end else begin
            cmd_d.op = req0_op;
            cmd_d.a  = req0_a;
            cmd_d.b  = req0_b;
          end
          rsp_id_d = pick1;
`ifdef ALU_ARB_RR_EN
          last_d   = pick1;
`endif
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_z_d     = alu_z;
        rsp_zero_d  = alu_zero;
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_id_q    <= rsp_id_d;
`ifdef ALU_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign alu_a     = cmd_q.a;
  assign alu_b     = cmd_q.b;
  assign alu_op    = cmd_q.op;
  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: models the shared ALU and predicts grants/results from the arbitration rules.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_z;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_zero, rsp_id;
  logic [31:0] rsp_z;

  int n_tests = 0;
  int n_fail  = 0;
  bit mdl_last;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_zero(rsp_zero), .rsp_id(rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Shared combinational ALU outside the DUT.
  always_comb begin
    alu_z    = ref_alu(alu_a, alu_b, alu_op);
    alu_zero = (alu_z == 32'd0);
  end

  function automatic bit exp_winner(input bit v0, input bit v1);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
`ifdef ALU_ARB_RR_EN
    return !mdl_last;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    mdl_last = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    n_tests++; if (rsp_z !== 32'd0 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp got z=%0h zero=%0b id=%0b exp 0/0/0", rsp_z, rsp_zero, rsp_id); end
    n_tests++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'b000) begin
      n_fail++; $display("FAIL reset_alu got a=%0h b=%0h op=%0b exp 0", alu_a, alu_b, alu_op); end
    step();
    n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got %0b%0b exp 00", req0_ready, req1_ready); end
    step();
    rst_n = 1'b1;
    mdl_last = 1'b1;
  endtask

  task automatic test_single_op();
    req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b010; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    n_tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_grant got %0b%0b exp 10", req0_ready, req1_ready); end
    step();
    req0_valid = 1'b0; mdl_last = 1'b0;
    n_tests++; if (req0_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_exec got ready=%0b rsp_valid=%0b exp 0/0", req0_ready, rsp_valid); end
    n_tests++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 3'b010) begin
      n_fail++; $display("FAIL single_alu got a=%0d b=%0d op=%0b exp 5/3/010", alu_a, alu_b, alu_op); end
    step();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== 32'd8 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp got v=%0b z=%0d id=%0b exp 1/8/0", rsp_valid, rsp_z, rsp_id); end
    step();
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_done got %0b exp 0", rsp_valid); end
  endtask

  task automatic test_back_pressure();
    req1_a = 32'd3; req1_b = 32'd3; req1_op = 3'b110; req1_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_grant1 got %0b exp 1", req1_ready); end
    step();
    mdl_last = 1'b1;
    req1_valid = 1'b0;
    req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b010; req0_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%0b z=%0h zero=%0b id=%0b exp 1/0/1/1", i, rsp_valid, rsp_z, rsp_zero, rsp_id); end
      n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_nogrant[%0d] got %0b exp 0", i, req0_ready); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_release_ready got %0b exp 0", req0_ready); end
    step();
    n_tests++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_idle got v=%0b ready0=%0b exp 0/1", rsp_valid, req0_ready); end
    step();
    req0_valid = 1'b0; mdl_last = 1'b0;
    step();
    n_tests++; if (rsp_z !== 32'd2 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL bp_next got z=%0d id=%0b exp 2/0", rsp_z, rsp_id); end
    step();
  endtask

  task automatic test_contention();
    bit          w;
    logic [31:0] exp_z;
    do_reset();
    rsp_ready = 1'b1;
    req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
    req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      w = exp_winner(1'b1, 1'b1);
      exp_z = w ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
      n_tests++; if (req0_ready !== !w || req1_ready !== w) begin
        n_fail++; $display("FAIL cont_grant[%0d] got %0b%0b exp winner %0d", k, req0_ready, req1_ready, w); end
      step();
      mdl_last = w;
      if (w) begin req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7)); end
      else   begin req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7)); end
      step();
      n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== w || rsp_z !== exp_z) begin
        n_fail++; $display("FAIL cont_rsp[%0d] got v=%0b id=%0b z=%0h exp 1/%0b/%0h", k, rsp_valid, rsp_id, rsp_z, w, exp_z); end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_slt_undef();
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [2:0]  ov [3];
    logic [31:0] ev [3];
    av[0] = 32'd2; bv[0] = 32'd7; ov[0] = 3'b111; ev[0] = 32'd1;
    av[1] = 32'd2; bv[1] = 32'd7; ov[1] = 3'b011; ev[1] = 32'd0;
    av[2] = $urandom; bv[2] = $urandom; ov[2] = 3'b111; ev[2] = ref_alu(av[2], bv[2], 3'b111);
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req0_a = av[k]; req0_b = bv[k]; req0_op = ov[k]; req0_valid = 1'b1;
      step();
      req0_valid = 1'b0; mdl_last = 1'b0;
      n_tests++; if (alu_op !== ov[k]) begin n_fail++; $display("FAIL op_fwd[%0d] got %0b exp %0b", k, alu_op, ov[k]); end
      step();
      n_tests++; if (rsp_z !== ev[k]) begin n_fail++; $display("FAIL op_result[%0d] got %0h exp %0h", k, rsp_z, ev[k]); end
      step();
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] na, nb;
    rsp_ready = 1'b1;
    req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b010; req0_valid = 1'b1;
    step();
    na = $urandom; nb = $urandom;
    req0_a = na; req0_b = nb; req0_op = 3'b000;
    rst_n = 1'b0;
    #1;
    n_tests++; if (rsp_valid !== 1'b0 || alu_a !== 32'd0 || alu_op !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_async got v=%0b a=%0h op=%0b exp 0/0/0", rsp_valid, alu_a, alu_op); end
    step();
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_held got %0b exp 0", rsp_valid); end
    rst_n = 1'b1; mdl_last = 1'b1;
    #1;
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant got %0b exp 1", req0_ready); end
    step();
    req0_valid = 1'b0; mdl_last = 1'b0;
    n_tests++; if (alu_a !== na || alu_b !== nb || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_load got a=%0h b=%0h v=%0b exp %0h/%0h/0", alu_a, alu_b, rsp_valid, na, nb); end
    step();
    n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== (na & nb)) begin
      n_fail++; $display("FAIL rstmid_rsp got v=%0b z=%0h exp 1/%0h", rsp_valid, rsp_z, na & nb); end
    step();
  endtask

  task automatic test_throughput();
    logic [31:0] expq[$];
    logic [31:0] e;
    int          nrsp = 0;
    rsp_ready = 1'b1;
    req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7)); req0_valid = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL tput_ready[%0d] got %0b exp 1", k, req0_ready); end
      expq.push_back(ref_alu(req0_a, req0_b, req0_op));
      step();
      mdl_last = 1'b0;
      if (k < 5) begin req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7)); end
      else req0_valid = 1'b0;
      step();
      e = expq.pop_front();
      if (rsp_valid === 1'b1) nrsp++;
      n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== e || rsp_id !== 1'b0) begin
        n_fail++; $display("FAIL tput_rsp[%0d] got v=%0b z=%0h id=%0b exp 1/%0h/0", k, rsp_valid, rsp_z, rsp_id, e); end
      step();
    end
    n_tests++; if (nrsp != 6 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL tput_count got %0d rsp, v=%0b exp 6/0", nrsp, rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_back_pressure();
    test_contention();
    test_slt_undef();
    test_reset_mid_op();
    test_throughput();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
